// File: rtl/chkmon_pkg.sv
// Shared types and constants for the checkpoint sequence monitor.
package chkmon_pkg;

  localparam int unsigned CYC_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_PASS,
    S_FAIL
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ORDER   = 2'd2;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v == '1) ? v : v + CYC_W'(1);
  endfunction

endpackage

// File: rtl/chkmon_stable_filter.sv
// Stability filter: pulses stable_o once per episode when the bus has held one value
// for STABLE_CYCLES consecutive samples; value_o is the value being sampled.
module chkmon_stable_filter #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  output logic             stable_o,
  output logic [WIDTH-1:0] value_o
);

  localparam int unsigned      RUN_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] prev_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic             valid_q;
  logic             same;

  always_comb begin
    same = valid_q && (data == prev_q);
    if (!same) begin
      run_d = RUN_W'(1);
    end else if (run_q == RUN_MAX) begin
      run_d = RUN_MAX;
    end else begin
      run_d = run_q + RUN_W'(1);
    end
    // Fire only on reaching the limit, not while saturated on the same value.
    stable_o = (run_d == RUN_MAX) && !(same && (run_q == RUN_MAX));
  end

  assign value_o = data;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev_q  <= '0;
      run_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      prev_q  <= data;
      run_q   <= run_d;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Ordered checkpoint-marker monitor with global timeout.
// Define CHKMON_ORDER_CHECK_EN to fail early on a stable out-of-order marker.
module checkpoint_seq_monitor
  import chkmon_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned NUM_CHECKS     = 4,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 300000,
  parameter int unsigned IDX_W          = $clog2(NUM_CHECKS + 1)
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        start_i,
  input  logic [IDX_W-1:0]            num_checks_i,
  input  logic [NUM_CHECKS*WIDTH-1:0] expected_i,
  input  logic [WIDTH-1:0]            checkbits_i,
  output logic                        busy_o,
  output logic                        hit_o,
  output logic [IDX_W-1:0]            hit_idx_o,
  output logic                        done_o,
  output logic                        pass_o,
  output logic [1:0]                  err_code_o,
  output logic [IDX_W-1:0]            stall_idx_o,
  output logic [CYC_W-1:0]            cycles_o
);

  state_e                      state_q, state_d;
  logic [NUM_CHECKS*WIDTH-1:0] mk_q;
  logic [IDX_W-1:0]            n_q, n_eff;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [IDX_W-1:0]            hit_idx_q, hit_idx_d;
  logic [CYC_W-1:0]            cyc_q, cyc_d;
  logic                        hit_q, hit_d;
  logic [1:0]                  err_q, err_d;
  logic                        arm;
  logic                        stable;
  logic [WIDTH-1:0]            value;
  logic [WIDTH-1:0]            cur;

  assign arm = start_i && (state_q != S_ARMED);

  chkmon_stable_filter #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (arm),
    .data    (checkbits_i),
    .stable_o(stable),
    .value_o (value)
  );

  always_comb begin
    if (num_checks_i == '0 || num_checks_i > IDX_W'(NUM_CHECKS)) begin
      n_eff = IDX_W'(NUM_CHECKS);
    end else begin
      n_eff = num_checks_i;
    end
  end

  always_comb begin
    cur = '0;
    for (int k = 0; k < NUM_CHECKS; k++) begin
      if (IDX_W'(k) == idx_q) cur = mk_q[k*WIDTH +: WIDTH];
    end
  end

`ifdef CHKMON_ORDER_CHECK_EN
  logic ooo;

  always_comb begin
    ooo = 1'b0;
    for (int k = 0; k < NUM_CHECKS; k++) begin
      if (IDX_W'(k) > idx_q && IDX_W'(k) < n_q && mk_q[k*WIDTH +: WIDTH] == value) ooo = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cyc_d     = cyc_q;
    hit_d     = 1'b0;
    hit_idx_d = hit_idx_q;
    err_d     = err_q;
    case (state_q)
      S_ARMED: begin
        cyc_d = sat_inc(cyc_q);
        if (stable && value == cur) begin
          hit_d     = 1'b1;
          hit_idx_d = idx_q;
          idx_d     = idx_q + IDX_W'(1);
          if (idx_d == n_q) state_d = S_PASS;
        end
`ifdef CHKMON_ORDER_CHECK_EN
        else if (stable && ooo) begin
          state_d = S_FAIL;
          err_d   = ERR_ORDER;
        end
`endif
        // A final hit on the timeout edge has already moved us to PASS.
        if (state_d == S_ARMED && cyc_d >= CYC_W'(TIMEOUT_CYCLES)) begin
          state_d = S_FAIL;
          err_d   = ERR_TIMEOUT;
        end
      end
      default: begin
        if (start_i) begin
          state_d = S_ARMED;
          idx_d   = '0;
          cyc_d   = '0;
          err_d   = ERR_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      mk_q      <= '0;
      n_q       <= '0;
      idx_q     <= '0;
      hit_idx_q <= '0;
      cyc_q     <= '0;
      hit_q     <= 1'b0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hit_idx_q <= hit_idx_d;
      cyc_q     <= cyc_d;
      hit_q     <= hit_d;
      err_q     <= err_d;
      if (arm) begin
        mk_q <= expected_i;
        n_q  <= n_eff;
      end
    end
  end

  assign busy_o      = (state_q == S_ARMED);
  assign hit_o       = hit_q;
  assign hit_idx_o   = hit_idx_q;
  assign done_o      = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass_o      = (state_q == S_PASS);
  assign err_code_o  = err_q;
  assign stall_idx_o = idx_q;
  assign cycles_o    = cyc_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Self-checking bench for checkpoint_seq_monitor against a behavioural sequence model.
module tb_checkpoint_seq_monitor;

  localparam int W  = 16;
  localparam int NC = 4;
  localparam int ST = 4;
  localparam int TO = 1000;
`ifdef CHKMON_ORDER_CHECK_EN
  localparam bit ORDER = 1'b1;
`else
  localparam bit ORDER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    num = '0;
  logic [63:0]   expd = '0;
  logic [15:0]   bus = '0;
  logic          busy, hit, done, pass;
  logic [2:0]    hit_idx, stall;
  logic [1:0]    err;
  logic [31:0]   cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  checkpoint_seq_monitor #(
    .WIDTH         (W),
    .NUM_CHECKS    (NC),
    .STABLE_CYCLES (ST),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .start_i     (start),
    .num_checks_i(num),
    .expected_i  (expd),
    .checkbits_i (bus),
    .busy_o      (busy),
    .hit_o       (hit),
    .hit_idx_o   (hit_idx),
    .done_o      (done),
    .pass_o      (pass),
    .err_code_o  (err),
    .stall_idx_o (stall),
    .cycles_o    (cycles)
  );

  // Reference model: 0 idle, 1 armed, 2 pass, 3 fail; run = samples of current value since arm.
  int          m_state, m_idx, m_n, m_hit_idx, m_err, m_run;
  bit          m_hit;
  longint      m_cyc;
  logic [15:0] m_prev;
  logic [15:0] m_mk[NC];

  task automatic model_edge();
    int run_new;
    bit st;
    bit ooo;
    if (rst) begin
      m_state = 0; m_idx = 0; m_n = 0; m_hit = 0; m_hit_idx = 0; m_err = 0;
      m_cyc = 0; m_run = 0; m_prev = '0;
      for (int k = 0; k < NC; k++) m_mk[k] = '0;
      return;
    end
    run_new = (m_run > 0 && bus == m_prev) ? m_run + 1 : 1;
    st = (run_new == ST);
    m_prev = bus;
    m_run = run_new;
    m_hit = 0;
    if (m_state == 1) begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (st && bus == m_mk[m_idx]) begin
        m_hit = 1; m_hit_idx = m_idx; m_idx++;
        if (m_idx == m_n) m_state = 2;
      end else if (ORDER && st) begin
        ooo = 0;
        for (int j = m_idx + 1; j < m_n; j++) if (m_mk[j] == bus) ooo = 1;
        if (ooo) begin m_state = 3; m_err = 2; end
      end
      if (m_state == 1 && m_cyc >= TO) begin m_state = 3; m_err = 1; end
    end else if (start) begin
      m_state = 1; m_idx = 0; m_cyc = 0; m_err = 0; m_run = 0;
      for (int k = 0; k < NC; k++) m_mk[k] = expd[k*16 +: 16];
      m_n = (num == 0 || num > NC) ? NC : int'(num);
    end
  endtask

  function automatic logic [43:0] dut_vec();
    return {busy, hit, hit_idx, done, pass, err, stall, cycles};
  endfunction

  function automatic logic [43:0] mdl_vec();
    return {m_state == 1, m_hit, 3'(m_hit_idx), m_state >= 2, m_state == 2, 2'(m_err),
            3'(m_idx), 32'(m_cyc)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic arm(input logic [2:0] n, input logic [63:0] e);
    start = 1'b1; num = n; expd = e;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    if (dut_vec() !== 44'h0) begin
      errors++;
      $display("FAIL reset outputs got %h want %h", dut_vec(), 44'h0);
    end
    checks++;
    rst = 1'b0;
    tick();
    if (dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL idle_after_reset got %h want %h", dut_vec(), mdl_vec());
    end
    checks++;
  endtask

  task automatic test_two_marker();
    int hits = 0;
    arm(3'd2, {32'h0, 16'h005A, 16'h00A5});
    for (int i = 0; i < 11; i++) begin
      bus = (i < 4) ? 16'h00A5 : (i < 8) ? 16'h005A : 16'h0000;
      tick();
      hits += int'(hit);
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL two_marker step %0d got %h want %h", i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    if ({pass, err, hits[3:0]} !== {1'b1, 2'd0, 4'd2}) begin
      errors++;
      $display("FAIL two_marker_end pass/err/hits got %b/%0d/%0d want 1/0/2", pass, err, hits);
    end
    checks++;
  endtask

  task automatic test_glitch();
    int hits = 0;
    int at = -1;
    arm(3'd2, {32'h0, 16'h005A, 16'h00A5});
    for (int i = 0; i < 11; i++) begin
      bus = (i < 3) ? 16'h00A5 : (i < 5) ? 16'h0000 : 16'h00A5;
      tick();
      if (hit) begin hits++; at = i; end
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL glitch step %0d got %h want %h", i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    if (hits != 1 || at != 8) begin
      errors++;
      $display("FAIL glitch_hit count/step got %0d/%0d want 1/8", hits, at);
    end
    checks++;
  endtask

  task automatic test_timeout();
    int i = 0;
    arm(3'd2, {32'h0, 16'h005A, 16'h00A5});
    while (!done && i < 1100) begin
      bus = (i < 6) ? 16'h00A5 : 16'h0000;
      tick();
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL timeout step %0d got %h want %h", i, dut_vec(), mdl_vec());
      end
      checks++;
      i++;
    end
    if ({done, pass, err, stall, cycles} !== {1'b1, 1'b0, 2'd1, 3'd1, 32'd1000}) begin
      errors++;
      $display("FAIL timeout_end done/pass/err/stall/cyc got %b/%b/%0d/%0d/%0d want 1/0/1/1/1000",
               done, pass, err, stall, cycles);
    end
    checks++;
  endtask

  task automatic test_repeat();
    int hits = 0;
    arm(3'd2, {32'h0, 16'h0011, 16'h0011});
    for (int i = 0; i < 27; i++) begin
      bus = (i < 20) ? 16'h0011 : (i < 21) ? 16'h0000 : 16'h0011;
      tick();
      hits += int'(hit);
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL repeat step %0d got %h want %h", i, dut_vec(), mdl_vec());
      end
      checks++;
      if (i == 19 && hits != 1) begin
        errors++;
        $display("FAIL repeat_single_hit got %0d want 1", hits);
      end
      if (i == 19) checks++;
    end
    if ({pass, hits[3:0]} !== {1'b1, 4'd2}) begin
      errors++;
      $display("FAIL repeat_end pass/hits got %b/%0d want 1/2", pass, hits);
    end
    checks++;
  endtask

  task automatic test_order();
    logic [7:0] want;
`ifdef CHKMON_ORDER_CHECK_EN
    want = {1'b1, 1'b0, 2'd2, 3'd0, 1'b0};
`else
    want = {1'b1, 1'b1, 2'd0, 3'd3, 1'b0};
`endif
    arm(3'd3, {16'h0, 16'h00FF, 16'h005A, 16'h00A5});
    for (int i = 0; i < 17; i++) begin
      bus = (i < 5) ? 16'h00FF : (i < 9) ? 16'h00A5 : (i < 13) ? 16'h005A : 16'h00FF;
      tick();
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL order step %0d got %h want %h", i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    if ({done, pass, err, stall, busy} !== want) begin
      errors++;
      $display("FAIL order_end done,pass,err,stall,busy got %b want %b",
               {done, pass, err, stall, busy}, want);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    arm(3'd3, {16'h0, 16'h00FF, 16'h005A, 16'h00A5});
    for (int i = 0; i < 6; i++) begin
      bus = (i < 4) ? 16'h00A5 : 16'h005A;
      tick();
    end
    if (stall !== 3'd1) begin
      errors++;
      $display("FAIL reset_mid_pre stall got %0d want 1", stall);
    end
    checks++;
    rst = 1'b1;
    tick();
    if (dut_vec() !== 44'h0) begin
      errors++;
      $display("FAIL reset_mid outputs got %h want %h", dut_vec(), 44'h0);
    end
    checks++;
    rst = 1'b0;
    arm(3'd2, {32'h0, 16'h005A, 16'h00A5});
    for (int i = 0; i < 9; i++) begin
      bus = (i < 4) ? 16'h00A5 : 16'h005A;
      tick();
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL reset_mid_rerun step %0d got %h want %h", i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    if ({pass, stall} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL reset_mid_end pass/stall got %b/%0d want 1/2", pass, stall);
    end
    checks++;
  endtask

  task automatic test_random();
    int hold;
    for (int run = 0; run < 20; run++) begin
      for (int k = 0; k < NC; k++) expd[k*16 +: 16] = 16'($urandom_range(1, 4));
      arm(3'($urandom_range(0, 7)), expd);
      hold = 0;
      for (int i = 0; i < 150; i++) begin
        if (hold == 0) begin
          bus = 16'($urandom_range(0, 4));
          hold = $urandom_range(1, 7);
        end
        hold--;
        start = ($urandom_range(0, 39) == 0);
        if (start) for (int k = 0; k < NC; k++) expd[k*16 +: 16] = 16'($urandom_range(1, 4));
        num = 3'($urandom_range(0, 7));
        rst = ($urandom_range(0, 299) == 0);
        tick();
        start = 1'b0;
        rst = 1'b0;
        if (dut_vec() !== mdl_vec()) begin
          errors++;
          $display("FAIL random run %0d step %0d got %h want %h", run, i, dut_vec(), mdl_vec());
        end
        checks++;
      end
      if (busy) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_marker();
    test_glitch();
    test_timeout();
    test_repeat();
    test_order();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
